keypad_scan: RTL and testbench

- 4x4 matrix hex keypad scanner. It is the input-side counterpart of the 8-digit seven-segment scan display.
- Drives keypad rows one at a time with an active-low select. Samples the active-low columns and debounces both press and release.
- Converts each accepted press into a hex digit and shifts that digit into a 32-bit entry word. The word feeds the display's 32-bit data input directly.
- Sits between the board keypad pins and the display/datapath.

---
 rtl/keypad_scan.sv | 172 +++++++++++++++++
 tb/tb_keypad_scan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: rotates active-low rows, debounces press and
// release, and shifts each accepted key into a 32-bit entry word.
module keypad_scan #(
  parameter int SCAN_W    = 11,
  parameter int DEB_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [32:1] data,
  output logic [3:0]  key,
  output logic        key_valid
);

  typedef enum logic [1:0] {
    SCAN,
    PRESS,
    HOLD
  } state_e;

  localparam logic [3:0] DEB = DEB_TICKS[3:0];

  state_e              state_q, state_d;
  logic [SCAN_W-1:0]   cnt_q;
  logic [3:0]          col_s1_q, col_s_q;
  logic [3:0]          deb_q, deb_d;
  logic [3:0]          row_q, row_d;
  logic [3:0]          cand_q, cand_d;
  logic [32:1]         data_q, data_d;
  logic [3:0]          key_q, key_d;
  logic                kv_q, kv_d;

  logic                tick;
  logic                one_low;
  logic                acc;
  logic [1:0]          ridx, cidx;
  logic [3:0]          code;
  logic [3:0]          row_rot;
  logic [3:0]          deb_inc;

  assign tick    = &cnt_q;
  assign row_rot = {row_q[2:0], row_q[3]};
  assign deb_inc = deb_q + 4'd1;
  assign code    = {ridx, cidx};

  always_comb begin
    ridx = 2'd0;
    case (row_q)
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
  end

  always_comb begin
    cidx    = 2'd0;
    one_low = 1'b1;
    case (col_s_q)
      4'b1110: cidx = 2'd0;
      4'b1101: cidx = 2'd1;
      4'b1011: cidx = 2'd2;
      4'b0111: cidx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    row_d   = row_q;
    cand_d  = cand_q;
    data_d  = data_q;
    key_d   = key_q;
    kv_d    = 1'b0;
    acc     = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            cand_d = col_s_q;
            if (DEB == 4'd1) begin
              acc     = 1'b1;
              deb_d   = 4'd0;
              state_d = HOLD;
            end else begin
              deb_d   = 4'd1;
              state_d = PRESS;
            end
          end else begin
            row_d = row_rot;
          end
        end
        PRESS: begin
          if (col_s_q == cand_q) begin
            if (deb_inc == DEB) begin
              acc     = 1'b1;
              deb_d   = 4'd0;
              state_d = HOLD;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d   = 4'd0;
            row_d   = row_rot;
            state_d = SCAN;
          end
        end
        HOLD: begin
          if (col_s_q == 4'hF) begin
            if (deb_inc == DEB) begin
              deb_d   = 4'd0;
              row_d   = row_rot;
              state_d = SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = 4'd0;
          end
        end
        default: begin
          deb_d   = 4'd0;
          state_d = SCAN;
        end
      endcase
    end
    if (acc) begin
      key_d  = code;
      kv_d   = 1'b1;
      data_d = {data_q[28:1], code};
    end
    // Clear beats a simultaneous accept on the entry word only
    if (clr) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      col_s1_q <= 4'hF;
      col_s_q  <= 4'hF;
      deb_q    <= 4'd0;
      row_q    <= 4'b1110;
      cand_q   <= 4'hF;
      data_q   <= '0;
      key_q    <= 4'd0;
      kv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_q + SCAN_W'(1);
      col_s1_q <= col;
      col_s_q  <= col_s1_q;
      deb_q    <= deb_d;
      row_q    <= row_d;
      cand_q   <= cand_d;
      data_q   <= data_d;
      key_q    <= key_d;
      kv_q     <= kv_d;
    end
  end

  assign row       = row_q;
  assign data      = data_q;
  assign key       = key_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad model drives col from row, a reference
// model tracks expected row/key/data every cycle.
module tb_keypad_scan;

  localparam int SW  = 3;
  localparam int DEB = 4;
  localparam int PER = 1 << SW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [32:1] data;
  logic [3:0]  key;
  logic        key_valid;

  logic        pk_on = 1'b0;
  int          pk_r = 0;
  int          pk_c = 0;
  logic        ov_on = 1'b0;
  logic [3:0]  ov_val = 4'hF;

  int vec  = 0;
  int miss = 0;
  int kv_cnt = 0;

  keypad_scan #(.SCAN_W(SW), .DEB_TICKS(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .col(col),
    .clr(clr),
    .row(row),
    .data(data),
    .key(key),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lowbit(int i);
    return 4'hF ^ (4'h1 << i);
  endfunction

  function automatic int zpos(logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (!v[i]) return i;
    return 0;
  endfunction

  // Physical keypad: a held key pulls its column low only while its row is driven
  always_comb begin
    if (ov_on) col = ov_val;
    else if (pk_on && row == lowbit(pk_r)) col = lowbit(pk_c);
    else col = 4'hF;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: row position, debounce phase and count as plain integers
  int          m_n;
  logic [3:0]  m_h1, m_h2;
  int          m_ridx, m_ph, m_cnt;
  logic [3:0]  m_cand;
  logic [31:0] m_data;
  int          m_key;
  bit          m_kv;

  task automatic m_step(logic [3:0] cs);
    int lows;
    lows = $countones(~cs);
    if (m_ph == 0) begin
      if (lows == 1) begin
        m_cand = cs;
        m_cnt = 1;
        m_ph = 1;
      end else m_ridx = (m_ridx + 1) % 4;
    end else if (m_ph == 1) begin
      if (cs == m_cand) begin
        m_cnt++;
        if (m_cnt == DEB) begin
          m_key = m_ridx * 4 + zpos(cs);
          m_kv = 1;
          m_data = (m_data << 4) | 32'(m_key);
          m_cnt = 0;
          m_ph = 2;
        end
      end else begin
        m_cnt = 0;
        m_ridx = (m_ridx + 1) % 4;
        m_ph = 0;
      end
    end else begin
      if (cs == 4'hF) m_cnt++;
      else m_cnt = 0;
      if (m_cnt == DEB) begin
        m_cnt = 0;
        m_ridx = (m_ridx + 1) % 4;
        m_ph = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_h1 = 4'hF; m_h2 = 4'hF;
      m_ridx = 0; m_ph = 0; m_cnt = 0;
      m_cand = 4'hF; m_data = 0; m_key = 0; m_kv = 0;
    end else begin
      logic [3:0] cs;
      cs = m_h2;
      m_h2 = m_h1;
      m_h1 = col;
      m_kv = 0;
      if (m_n % PER == PER - 1) m_step(cs);
      m_n++;
      if (clr) m_data = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("row", 32'(row), 32'(lowbit(m_ridx)));
      chk("key_valid", 32'(key_valid), 32'(m_kv));
      chk("key", 32'(key), 32'(m_key));
      chk("data", 32'(data), m_data);
      if (key_valid) kv_cnt++;
    end
  end

  task automatic tick_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_kv(string tag, int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (key_valid) ok = 1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic enter(int k);
    pk_r = k / 4;
    pk_c = k % 4;
    pk_on = 1'b1;
    wait_kv("accept", 20 * PER);
    chk("accept_key", 32'(key), 32'(k));
    tick_n(PER);
    pk_on = 1'b0;
    tick_n(7 * PER);
  endtask

  initial begin
    int k0;
    tick_n(3);
    chk("rst_row", 32'(row), 32'hE);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_kv", 32'(key_valid), 32'h0);
    chk("rst_key", 32'(key), 32'h0);
    #2 rst = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      tick_n(PER);
      chk("rotate", 32'(row), 32'(lowbit(i % 4)));
    end

    // Single key 6 held, one pulse, row frozen while held
    k0 = kv_cnt;
    pk_r = 1; pk_c = 2; pk_on = 1'b1;
    wait_kv("k6_accept", 20 * PER);
    chk("k6_key", 32'(key), 32'h6);
    chk("k6_data", 32'(data), 32'h0000_0006);
    tick_n(6 * PER);
    chk("k6_row_frozen", 32'(row), 32'hD);
    pk_on = 1'b0;
    tick_n(7 * PER);
    chk("k6_once", 32'(kv_cnt - k0), 32'd1);

    for (int k = 1; k <= 9; k++) begin
      enter(k);
      if (k == 8) chk("seq8", 32'(data), 32'h1234_5678);
    end
    chk("seq9", 32'(data), 32'h2345_6789);

    // Key 0 bouncing on alternate ticks must never be accepted
    k0 = kv_cnt;
    pk_r = 0; pk_c = 0;
    for (int i = 0; i < 24; i++) begin
      pk_on = i[0];
      tick_n(PER);
    end
    chk("bounce_none", 32'(kv_cnt - k0), 32'd0);
    pk_on = 1'b1;
    wait_kv("bounce_accept", 20 * PER);
    chk("bounce_key", 32'(key), 32'h0);
    pk_on = 1'b0;
    tick_n(7 * PER);
    chk("bounce_data", 32'(data), 32'h3456_7890);

    // Two columns low together
    k0 = kv_cnt;
    ov_on = 1'b1; ov_val = 4'b1100;
    tick_n(12 * PER);
    ov_on = 1'b0;
    tick_n(3 * PER);
    chk("ghost_none", 32'(kv_cnt - k0), 32'd0);
    chk("ghost_data", 32'(data), 32'h3456_7890);

    enter(13); enter(14); enter(10); enter(13);
    enter(11); enter(14); enter(14); enter(15);
    chk("deadbeef", 32'(data), 32'hDEAD_BEEF);
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    chk("clr", 32'(data), 32'h0);

    // Reset while in release-wait with the key still down
    pk_r = 1; pk_c = 1; pk_on = 1'b1;
    wait_kv("hold_accept", 20 * PER);
    tick_n(PER);
    #2 rst = 1'b1;
    tick_n(1);
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_row", 32'(row), 32'hE);
    chk("mid_rst_kv", 32'(key_valid), 32'h0);
    #2 rst = 1'b0;
    wait_kv("repress", 20 * PER);
    chk("repress_key", 32'(key), 32'h5);
    chk("repress_data", 32'(data), 32'h0000_0005);
    pk_on = 1'b0;
    tick_n(7 * PER);

    // Random presses with chatter, clears and stray column patterns
    for (int it = 0; it < 60; it++) begin
      int len;
      pk_r = $urandom_range(0, 3);
      pk_c = $urandom_range(0, 3);
      len = $urandom_range(1, 14 * PER);
      for (int j = 0; j < len; j++) begin
        pk_on = ($urandom_range(0, 31) != 0);
        clr = ($urandom_range(0, 63) == 0);
        ov_on = ($urandom_range(0, 99) == 0);
        ov_val = 4'($urandom_range(0, 15));
        tick_n(1);
      end
      pk_on = 1'b0; clr = 1'b0; ov_on = 1'b0;
      tick_n($urandom_range(0, 8 * PER));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
